// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if: one classic wishbone link between a bus master and a slave.
//
// Signals
//   cyc, stb      master -> slave   cycle / strobe
//   addr[29:0]    master -> slave   word address (byte address bits [31:2])
//   cti[2:0]      master -> slave   cycle type identifier
//   bte[1:0]      master -> slave   burst type extension
//   sel[3:0]      master -> slave   byte selects
//   we            master -> slave   write enable
//   wdata[31:0]   master -> slave   write data
//   rdata[31:0]   slave  -> master  read data
//   ack, err      slave  -> master  transfer acknowledge / error
//
// Modports
//   master : the side that starts cycles
//   slave  : the side that answers them
interface wb_mem_arbiter_if;
    logic        cyc;
    logic        stb;
    logic [29:0] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, addr, cti, bte, sel, we, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  cyc, stb, addr, cti, bte, sel, we, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master, one-slave wishbone arbiter for the Nexys3 memory port.
// Round-robin grant, held for a whole cyc; at least one idle cycle between owners.
//
// Ports
//   clk          in   wishbone clock
//   rst          in   synchronous reset, active-high
//   m0, m1       wb_mem_arbiter_if.slave   the two requesting masters
//   s            wb_mem_arbiter_if.master  link to the memory slave
//   grant[1:0]   out  one-hot owner (bit0 = m0, bit1 = m1), 2'b00 when idle
//
// Parameters
//   TIMEOUT_BITS watchdog width; abort after 2**TIMEOUT_BITS-1 stalled cycles
//
// Build option
//   WB_ARB_TIMEOUT_EN  when defined, a watchdog raises err to the owner after
//                      a stalled strobe and parks the arbiter in ABORT until
//                      the owner drops cyc. Undefined: no watchdog at all.
module wb_mem_arbiter #(
    parameter int unsigned TIMEOUT_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    wb_mem_arbiter_if.slave  m0,
    wb_mem_arbiter_if.slave  m1,
    wb_mem_arbiter_if.master s,
    output logic [1:0]       grant
);

    if (TIMEOUT_BITS < 1) begin : g_bad_timeout_bits
        $error("wb_mem_arbiter: TIMEOUT_BITS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ABORT
    } state_t;

    state_t     r_state;
    logic       r_owner;   // 0 = m0, 1 = m1
    logic       r_last;    // previous owner, loses a tie
    logic [1:0] r_grant;

    logic        w_busy;
    logic        w_pick;
    logic        w_to;
    logic        w_own_cyc;
    logic        w_own_stb;
    logic [29:0] w_own_addr;
    logic [2:0]  w_own_cti;
    logic [1:0]  w_own_bte;
    logic [3:0]  w_own_sel;
    logic        w_own_we;
    logic [31:0] w_own_wdata;

    assign w_busy = (r_state == ST_BUSY);

    // Single requester wins outright; on a tie the one that did not go last wins.
    assign w_pick = (m0.cyc && m1.cyc) ? ~r_last : m1.cyc;

    assign w_own_cyc   = r_owner ? m1.cyc   : m0.cyc;
    assign w_own_stb   = r_owner ? m1.stb   : m0.stb;
    assign w_own_addr  = r_owner ? m1.addr  : m0.addr;
    assign w_own_cti   = r_owner ? m1.cti   : m0.cti;
    assign w_own_bte   = r_owner ? m1.bte   : m0.bte;
    assign w_own_sel   = r_owner ? m1.sel   : m0.sel;
    assign w_own_we    = r_owner ? m1.we    : m0.we;
    assign w_own_wdata = r_owner ? m1.wdata : m0.wdata;

    // Slave side is driven only while BUSY; IDLE and ABORT present a quiet bus.
    assign s.cyc   = w_busy & w_own_cyc;
    assign s.stb   = w_busy & w_own_stb;
    assign s.addr  = w_busy ? w_own_addr  : 30'd0;
    assign s.cti   = w_busy ? w_own_cti   : 3'd0;
    assign s.bte   = w_busy ? w_own_bte   : 2'd0;
    assign s.sel   = w_busy ? w_own_sel   : 4'd0;
    assign s.we    = w_busy & w_own_we;
    assign s.wdata = w_busy ? w_own_wdata : 32'd0;

    // Read data is shared; only the owner ever sees ack/err, so the
    // non-owner simply ignores whatever is on rdata.
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.ack   = w_busy & ~r_owner & s.ack;
    assign m1.ack   = w_busy &  r_owner & s.ack;
    assign m0.err   = w_busy & ~r_owner & (s.err | w_to);
    assign m1.err   = w_busy &  r_owner & (s.err | w_to);

    assign grant = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] WDOG_MAX = '1;

    logic [TIMEOUT_BITS-1:0] r_wdog;
    logic                    w_stall;

    // Stalled = strobing in BUSY with no response. Leaving BUSY drops
    // w_busy, so a change of owner always starts the count from zero.
    assign w_stall = w_busy & s.stb & ~s.ack & ~s.err;

    // r_wdog holds the number of consecutive stalled cycles before this one.
    assign w_to = w_stall & (r_wdog == WDOG_MAX);

    always_ff @(posedge clk) begin
        if (rst || !w_stall || w_to) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (m0.cyc || m1.cyc) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_pick;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                    end
                end
                ST_BUSY: begin
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_owner;
                        r_grant <= 2'b00;
                    end else if (w_to) begin
                        r_state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    // Bus stays quiet; wait for the owner to give up its cycle.
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_owner;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scoreboard bench for wb_mem_arbiter.
// Bench slave answers with data derived from the request it saw.
module tb_wb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_mem_arbiter_if if_m0();
    wb_mem_arbiter_if if_m1();
    wb_mem_arbiter_if if_s();
    logic [1:0] grant;

    wb_mem_arbiter #(.TIMEOUT_BITS(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (if_m0),
        .m1    (if_m1),
        .s     (if_s),
        .grant (grant)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_ack1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int slv_lat = 0;
    bit slv_err = 1'b0;
    bit slv_dead = 1'b0;
    int s_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [29:0] a, input logic we,
                                           input logic [31:0] wd, input logic [3:0] sel,
                                           input logic [2:0] cti, input logic [1:0] bte);
        if (a == 30'h40 && !we && sel == 4'h3) return 32'hDEADBEEF;
        return {a, 2'b00} ^ 32'h5A5A_0000 ^ (we ? wd : 32'h0)
               ^ {sel, 23'h0, bte, cti};
    endfunction

    // Bench slave: samples the bus at the edge, answers 2 time units later.
    always @(posedge clk) begin
        logic        go;
        logic [31:0] rd;
        go = if_s.cyc && if_s.stb && !if_s.ack && !if_s.err && !slv_dead;
        rd = exp_rd(if_s.addr, if_s.we, if_s.wdata, if_s.sel, if_s.cti, if_s.bte);
        if (go && s_cnt >= slv_lat) begin
            s_cnt = 0;
            #2;
            if_s.rdata = rd;
            if_s.ack   = !slv_err;
            if_s.err   = slv_err;
        end else begin
            s_cnt = go ? s_cnt + 1 : 0;
            #2;
            if_s.rdata = 32'h0;
            if_s.ack   = 1'b0;
            if_s.err   = 1'b0;
        end
    end

    // Scoreboard: every ack pops the expected read data of that master.
    always @(negedge clk) begin
        if (if_m0.ack) begin
            chk("m0_ack_owner", 32'(grant), 32'd1);
            if (q0.size() == 0) chk("m0_ack_unexp", 32'(q0.size()), 32'd1);
            else chk("m0_rdata", if_m0.rdata, q0.pop_front());
        end
        if (if_m1.ack) begin
            n_ack1++;
            chk("m1_ack_owner", 32'(grant), 32'd2);
            if (q1.size() == 0) chk("m1_ack_unexp", 32'(q1.size()), 32'd1);
            else chk("m1_rdata", if_m1.rdata, q1.pop_front());
        end
    end

    task automatic drv(input bit who, input logic cyc, input logic stb,
                       input logic [29:0] a, input logic [2:0] cti,
                       input logic [3:0] sel, input logic we, input logic [31:0] wd);
        if (who) begin
            if_m1.cyc = cyc; if_m1.stb = stb; if_m1.addr = a; if_m1.cti = cti;
            if_m1.bte = 2'b00; if_m1.sel = sel; if_m1.we = we; if_m1.wdata = wd;
        end else begin
            if_m0.cyc = cyc; if_m0.stb = stb; if_m0.addr = a; if_m0.cti = cti;
            if_m0.bte = 2'b00; if_m0.sel = sel; if_m0.we = we; if_m0.wdata = wd;
        end
    endtask

    // Call aligned #1 after a posedge; returns aligned the same way.
    task automatic m_xfer(input bit who, input logic [29:0] a0,
                          input int beats, input bit we);
        for (int b = 0; b < beats; b++) begin
            logic [29:0] a;
            logic [2:0]  cti;
            logic [3:0]  sel;
            logic [31:0] wd;
            int          n;
            a   = a0 + 30'(b);
            cti = (beats == 1) ? 3'b000 : (b == beats - 1) ? 3'b111 : 3'b010;
            sel = (beats == 1) ? 4'h3 : 4'hF;
            wd  = {16'hC0DE, 16'(b)} ^ {2'b00, a};
            drv(who, 1'b1, 1'b1, a, cti, sel, we, wd);
            if (who) q1.push_back(exp_rd(a, we, wd, sel, cti, 2'b00));
            else     q0.push_back(exp_rd(a, we, wd, sel, cti, 2'b00));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(who ? if_m1.ack : if_m0.ack) && n < 100);
            if (n >= 100) chk(who ? "m1_ack_tmo" : "m0_ack_tmo", 32'(n), 32'd0);
            @(posedge clk); #1;
        end
        drv(who, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic wait_grant(input logic [1:0] g, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant !== g && n < budget);
        if (grant !== g) chk("grant_tmo", 32'(grant), 32'(g));
    endtask

    task automatic settle();
        int n;
        wait_grant(2'b00, 50, n);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        drv(1'b0, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        if_s.rdata = 32'h0; if_s.ack = 1'b0; if_s.err = 1'b0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_scyc", 32'(if_s.cyc), 32'd0);
        chk("rst_acks", {28'h0, if_m0.ack, if_m1.ack, if_m0.err, if_m1.err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: single m0 read, grant latency one cycle
        slv_lat = 2;
        fork
            m_xfer(1'b0, 30'h40, 1, 1'b0);
            begin
                @(negedge clk);
                chk("t1_pre_scyc", 32'(if_s.cyc), 32'd0);
                @(negedge clk);
                chk("t1_scyc", 32'(if_s.cyc), 32'd1);
                chk("t1_grant", 32'(grant), 32'd1);
                chk("t1_saddr", 32'(if_s.addr), 32'h40);
            end
        join
        settle();

        // 2: tie from reset, one idle cycle between owners, then alternation
        do_reset();
        slv_lat = 1;
        fork
            m_xfer(1'b0, 30'h80, 1, 1'b1);
            m_xfer(1'b1, 30'h90, 1, 1'b0);
            begin
                @(negedge clk); @(negedge clk);
                chk("t2_first", 32'(grant), 32'd1);
                wait_grant(2'b00, 20, n);
                chk("t2_gap_scyc", 32'(if_s.cyc), 32'd0);
                wait_grant(2'b10, 5, n);
                chk("t2_gap_len", 32'(n), 32'd1);
            end
        join
        settle();
        fork
            m_xfer(1'b0, 30'hA0, 1, 1'b0);
            m_xfer(1'b1, 30'hB0, 1, 1'b1);
            begin
                @(negedge clk); @(negedge clk);
                chk("t2_alt", 32'(grant), 32'd1);
            end
        join
        settle();

        // 3: m1 4-beat burst, m0 arrives at beat 2 and waits
        n = n_ack1;
        fork
            begin
                int k;
                m_xfer(1'b1, 30'h200, 4, 1'b0);
                wait_grant(2'b01, 10, k);
                chk("t3_grant_lat", 32'(k), 32'd3);
            end
            begin
                int k;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!if_m1.ack && k < 50);
                @(posedge clk); #1;
                m_xfer(1'b0, 30'h300, 1, 1'b1);
            end
        join
        chk("t3_m1_acks", 32'(n_ack1 - n), 32'd4);
        settle();

        // 4: slave error routed to owner only, grant held until cyc drops
        slv_lat = 1;
        slv_err = 1'b1;
        drv(1'b0, 1'b1, 1'b1, 30'h55, 3'b000, 4'hF, 1'b0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_s.err && n < 20);
        chk("t4_m0_err", 32'(if_m0.err), 32'd1);
        chk("t4_m1_err", 32'(if_m1.err), 32'd0);
        chk("t4_m0_ack", 32'(if_m0.ack), 32'd0);
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 1'b0, 30'h55, 3'b000, 4'hF, 1'b0, 32'h0);
        slv_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold", 32'(grant), 32'd1);
        end
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("t4_release", 32'(grant), 32'd0);
        @(posedge clk); #1;

        // 5: stalled slave
        slv_dead = 1'b1;
        drv(1'b0, 1'b1, 1'b1, 30'h66, 3'b000, 4'hF, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("t5_stb", 32'(if_s.stb), 32'd1);
`ifdef WB_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_m0.err && n < 40);
        chk("t5_to_lat", 32'(n), 32'd15);
        chk("t5_m1_err", 32'(if_m1.err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_abort_scyc", 32'(if_s.cyc), 32'd0);
            chk("t5_err_pulse", 32'(if_m0.err), 32'd0);
        end
`else
        repeat (20) @(negedge clk);
        chk("t5_no_to_err", 32'(if_m0.err), 32'd0);
        chk("t5_held", 32'(if_s.cyc), 32'd1);
`endif
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("t5_idle", 32'(grant), 32'd0);
        @(posedge clk); #1;

        // 6: reset in the middle of an m1 burst (m0 went last, so m1 wins the tie)
        drv(1'b1, 1'b1, 1'b1, 30'h400, 3'b010, 4'hF, 1'b0, 32'h0);
        drv(1'b0, 1'b1, 1'b1, 30'h500, 3'b000, 4'hF, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("t6_m1_own", 32'(grant), 32'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_pre_rst", 32'(if_s.cyc), 32'd1);
        @(negedge clk);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_scyc", 32'(if_s.cyc), 32'd0);
        chk("t6_rst_acks", {28'h0, if_m0.ack, if_m1.ack, if_m0.err, if_m1.err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_post_idle", 32'(grant), 32'd0);
        @(negedge clk);
        chk("t6_m0_wins", 32'(grant), 32'd1);
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 30'h0, 3'b000, 4'h0, 1'b0, 32'h0);
        slv_dead = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_q0_empty", 32'(q0.size()), 32'd0);
        chk("sb_q1_empty", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d exp %0d", n_chk, 0);
        $fatal(1, "timeout");
    end

endmodule
